// File: rtl/pe_sm_dot_accum.sv
// Sign-magnitude dot-accumulate element: per-beat lane sum through a registered
// adder tree, then a saturating group accumulator with a held output register.
module pe_sm_dot_accum #(
    parameter int unsigned SIZE  = 5,
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [LANES*SIZE-1:0]   in_mag,
    input  logic [LANES-1:0]        in_sign,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_sat
);

    localparam int unsigned L   = $clog2(LANES);
    localparam int unsigned BW  = SIZE + 1 + L;
    localparam int unsigned AW1 = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACC_IDLE,
        ACC_BUSY
    } acc_state_t;

    logic advance;
    logic [L:1] s_vld;
    logic [L:1] s_fst;
    logic [L:1] s_lst;
    logic signed [SIZE:0] lane_v [LANES];
    logic signed [BW-1:0] beat;

    // A held, unconsumed result freezes every stage at once.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_v[i] = in_sign[i] ? -$signed({1'b0, in_mag[i*SIZE +: SIZE]})
                                   :  $signed({1'b0, in_mag[i*SIZE +: SIZE]});
        end
    end

    // Level k holds LANES>>k partial sums, each one bit wider than level k-1.
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int unsigned W = SIZE + 1 + k;
        localparam int unsigned N = LANES >> k;
        logic signed [W-1:0] sum [N];

        if (k == 1) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned j = 0; j < N; j++) sum[j] <= '0;
                end else if (advance) begin
                    for (int unsigned j = 0; j < N; j++)
                        sum[j] <= W'(lane_v[2*j]) + W'(lane_v[2*j+1]);
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned j = 0; j < N; j++) sum[j] <= '0;
                end else if (advance) begin
                    for (int unsigned j = 0; j < N; j++)
                        sum[j] <= W'(g_lvl[k-1].sum[2*j]) + W'(g_lvl[k-1].sum[2*j+1]);
                end
            end
        end
    end

    assign beat = g_lvl[L].sum[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld <= '0;
            s_fst <= '0;
            s_lst <= '0;
        end else if (advance) begin
            s_vld[1] <= in_valid;
            s_fst[1] <= in_first;
            s_lst[1] <= in_last;
            for (int unsigned k = 2; k <= L; k++) begin
                s_vld[k] <= s_vld[k-1];
                s_fst[k] <= s_fst[k-1];
                s_lst[k] <= s_lst[k-1];
            end
        end
    end

    acc_state_t              state, state_nx;
    logic signed [ACC_W-1:0] acc, acc_nx;
    logic                    sticky, sticky_nx;
    logic signed [ACC_W-1:0] out_sum_nx;
    logic                    out_sat_nx, out_valid_nx;
    logic                    restart, sticky_base, ovf;
    logic signed [ACC_W-1:0] base, clamped;
    logic signed [AW1-1:0]   wide;

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        sticky_nx    = sticky;
        out_sum_nx   = out_sum;
        out_sat_nx   = out_sat;
        out_valid_nx = out_valid;

        restart     = s_fst[L] || (state == ACC_IDLE);
        base        = restart ? '0 : acc;
        sticky_base = restart ? 1'b0 : sticky;
        wide        = AW1'(base) + AW1'(beat);
        ovf         = wide[ACC_W] != wide[ACC_W-1];
        clamped     = ovf ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];

        // When advancing, any presented result is consumed this cycle.
        if (advance) begin
            out_valid_nx = 1'b0;
            if (s_vld[L]) begin
                if (s_lst[L]) begin
                    out_sum_nx   = clamped;
                    out_sat_nx   = sticky_base | ovf;
                    out_valid_nx = 1'b1;
                    acc_nx       = '0;
                    sticky_nx    = 1'b0;
                    state_nx     = ACC_IDLE;
                end else begin
                    acc_nx    = clamped;
                    sticky_nx = sticky_base | ovf;
                    state_nx  = ACC_BUSY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC_IDLE;
            acc       <= '0;
            sticky    <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            sticky    <= sticky_nx;
            out_sum   <= out_sum_nx;
            out_sat   <= out_sat_nx;
            out_valid <= out_valid_nx;
        end
    end

endmodule

// File: tb/tb_pe_sm_dot_accum.sv
// Scoreboard bench for pe_sm_dot_accum: directed beats push expected group
// results; a negedge monitor pops and compares each delivered result.
module tb_pe_sm_dot_accum;

    localparam int SIZE  = 5;
    localparam int LANES = 4;
    localparam int ACC_W = 10;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_first;
    logic                    in_last;
    logic [LANES*SIZE-1:0]   in_mag;
    logic [LANES-1:0]        in_sign;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_sat;

    pe_sm_dot_accum #(.SIZE(SIZE), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_mag    (in_mag),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    sum;
        logic  sat;
        string name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input string name, input int sum, input logic sat);
        exp_t x;
        x.sum  = sum;
        x.sat  = sat;
        x.name = name;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got sum=%0d sat=%0d expected none",
                         out_sum, out_sat);
            end else begin
                e = q.pop_front();
                if (out_sum != e.sum || out_sat != e.sat) begin
                    bad++;
                    $display("FAIL %s: got sum=%0d sat=%0d expected sum=%0d sat=%0d",
                             e.name, out_sum, out_sat, e.sum, e.sat);
                end
            end
        end
    end

    task automatic beat(input logic [4:0] m0, input logic [4:0] m1,
                        input logic [4:0] m2, input logic [4:0] m3,
                        input logic [3:0] s, input logic f, input logic l);
        logic ok;
        int   budget;
        in_mag   = {m3, m2, m1, m0};
        in_sign  = s;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        ok       = 1'b0;
        budget   = 0;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!ok && budget > 50) begin
                total++;
                bad++;
                $display("FAIL beat_accept_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_mag    = '0;
        in_sign   = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_sat", out_sat, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // One-beat group: 3 - 5 + 7 - 31 = -26, result three cycles after accept
        push("one_beat", -26, 1'b0);
        beat(3, 5, 7, 31, 4'b1010, 1'b1, 1'b1);
        @(negedge clk); check("lat_t1", out_valid, 0);
        @(negedge clk); check("lat_t2", out_valid, 0);
        @(negedge clk); check("lat_t3", out_valid, 1);
        drain("drain_one_beat");

        push("neg_zero", 0, 1'b0);
        beat(0, 0, 0, 0, 4'b1111, 1'b1, 1'b1);
        drain("drain_neg_zero");

        // 3 beats of 4*31 = 372
        push("three_beat", 372, 1'b0);
        beat(31, 31, 31, 31, 4'b0000, 1'b1, 1'b0);
        beat(31, 31, 31, 31, 4'b0000, 1'b0, 1'b0);
        beat(31, 31, 31, 31, 4'b0000, 1'b0, 1'b1);
        drain("drain_three_beat");

        // 5 * 124 = 620 clamps to 511; -620 clamps to -512
        push("sat_pos", 511, 1'b1);
        for (int i = 0; i < 5; i++) beat(31, 31, 31, 31, 4'b0000, i == 0, i == 4);
        drain("drain_sat_pos");
        push("sat_neg", -512, 1'b1);
        for (int i = 0; i < 5; i++) beat(31, 31, 31, 31, 4'b1111, i == 0, i == 4);
        drain("drain_sat_neg");

        // Saturated partial group abandoned by a new first beat
        for (int i = 0; i < 5; i++) beat(31, 31, 31, 31, 4'b0000, i == 0, 1'b0);
        push("restart_mid", 10, 1'b0);
        beat(10, 0, 0, 0, 4'b0000, 1'b1, 1'b1);
        drain("drain_restart_mid");

        // No first after a finished group: 7 + (-1 + 1 + 1 + 1) = 9
        push("no_first", 9, 1'b0);
        beat(7, 0, 0, 0, 4'b0000, 1'b0, 1'b0);
        beat(1, 1, 1, 1, 4'b0001, 1'b0, 1'b1);
        drain("drain_no_first");

        // Stall with two groups in flight: A = 46, B = 1 + 2 - 3 + 4 = 4
        out_ready = 1'b0;
        push("stall_a", 46, 1'b0);
        beat(3, 5, 7, 31, 4'b0000, 1'b1, 1'b1);
        push("stall_b", 4, 1'b0);
        beat(1, 2, 3, 4, 4'b0100, 1'b1, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_hold_sum", out_sum, 46);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("drain_stall");

        // Reset mid-group, then a fresh one-beat group of +10
        beat(31, 31, 31, 31, 4'b0000, 1'b1, 1'b0);
        beat(31, 31, 31, 31, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_sum", out_sum, 0);
        check("midrst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        push("after_reset", 10, 1'b0);
        beat(10, 0, 0, 0, 4'b0000, 1'b1, 1'b1);
        drain("drain_after_reset");

        repeat (10) @(posedge clk);
        #1;
        check("final_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_sm_dot_accum.md
PE_SM_DOT_ACCUM -- requirements
Module: pe_sm_dot_accum

Interface
REQ-001 SHALL have parameter SIZE, default 5: magnitude width per lane.
REQ-002 SHALL have parameter LANES, default 4: lanes summed per beat; power of two, at least 2.
REQ-003 SHALL have parameter ACC_W, default 16: signed accumulator and output width; at least SIZE+1+log2(LANES).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: input beat present.
REQ-007 SHALL have port in_ready, output, 1: block accepts the beat this cycle.
REQ-008 SHALL have port in_first, input, 1: beat starts a new accumulation group.
REQ-009 SHALL have port in_last, input, 1: beat ends the group.
REQ-010 SHALL have port in_mag, input, LANES*SIZE: lane i magnitude in bits [i*SIZE +: SIZE].
REQ-011 SHALL have port in_sign, input, LANES: lane i sign; 1 means negative.
REQ-012 SHALL have port out_valid, output, 1: group result present.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port out_sum, output, ACC_W, signed: group result.
REQ-015 SHALL have port out_sat, output, 1: group result was clamped.

Function
REQ-016 SHALL convert each lane to two's complement as sign ? -mag : mag, in SIZE+1 bits; sign=1 with mag=0 SHALL yield 0.
REQ-017 SHALL sum lanes in a registered binary tree of L=log2(LANES) stages; each level widens by 1 bit; lane conversion SHALL be in the first stage.
REQ-018 SHALL accept a beat when in_valid && in_ready at a rising edge.
REQ-019 SHALL pipeline by stalling globally: advance = !(out_valid && !out_ready); in_ready = advance; no stage or the accumulator SHALL change while stalled.
REQ-020 SHALL carry valid, first and last flags alongside the data through every tree stage; bubbles SHALL NOT change the accumulator.
REQ-021 SHALL, at the accumulate stage, load the beat sum if the beat is first or the accumulator is idle; otherwise it SHALL add the beat sum to the accumulator.
REQ-022 SHALL saturate the accumulation to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; once a group clamps, it SHALL keep a sticky group flag set until the group ends.
REQ-023 SHALL, on the last beat, load out_sum with the final value and out_sat with the group flag; it SHALL then set out_valid, clear the accumulator to 0 and mark it idle.
REQ-024 SHALL present out_sum in cycle t+L+1 for a last beat accepted in cycle t with no stall.
REQ-025 SHALL hold out_valid, out_sum and out_sat stable until out_valid && out_ready; if no new result arrives in that cycle, out_valid SHALL drop.
REQ-026 SHALL, when out_valid && out_ready and a new result arrives in the same cycle, load the new result with out_valid remaining 1 and no bubble.
REQ-027 SHALL, when in_first arrives mid-group, discard the partial sum and clear the sticky flag.
REQ-028 SHALL treat a beat with in_first && in_last as a complete one-beat group.
REQ-029 SHALL treat a beat with no in_first after a completed group as the start of a new group from 0.

Reset
REQ-030 SHALL, while rst_n=0, immediately clear all stage valids, accumulator, sticky flag, out_sum, out_valid and out_sat to 0, and mark the accumulator idle.
REQ-031 SHALL drive in_ready=1 after rst_n deasserts.
REQ-032 SHALL discard any in-flight or partial group on reset.

Verification
REQ-033 SHALL cover one beat with first and last, mags {3,5,7,31}, signs {0,1,0,1} -> out_sum=-26, out_sat=0, out_valid at t+3 (LANES=4).
REQ-034 SHALL cover all mags 0 with all signs 1 as a single group -> out_sum=0.
REQ-035 SHALL cover a 3-beat group with all lanes mag 31, sign 0 -> out_sum=372, one out_valid pulse.
REQ-036 SHALL cover, with ACC_W=10, 5 beats of +124 -> out_sum=511, out_sat=1; and the negative case -> out_sum=-512, out_sat=1.
REQ-037 SHALL cover out_ready=0 for 6 cycles with 2 groups in flight -> in_ready=0, out_sum held, both results delivered in order with no loss or duplication.
REQ-038 SHALL cover rst_n pulsed low after 2 beats of a group, then a single-beat group of +10 -> out_sum=10, out_sat=0.
